// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single-ported data memory.
// Master 0 is the CPU, master 1 is the DMA/peripheral master. One command
// is accepted per IDLE cycle; writes take one memory cycle and reads take
// an extra cycle to return data to the owning master.
module mem_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_be,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [31:0]      m0_rdata,

    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_be,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,

    output logic [31:0]      memaddr,
    output logic             memwrite,
    output logic             memread,
    output logic [31:0]      writedata,
    output logic [3:0]       be,
    input  logic [31:0]      readdata,

    output logic             busy,
    output logic             owner,
    output logic [CNT_W-1:0] gcnt0,
    output logic [CNT_W-1:0] gcnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    logic   last_owner;   // resets to 1 so that m0 wins the first tie
    logic   cmd_we;
    logic   any_req;
    logic   winner;
    logic   take;

    // Round-robin pick: a lone requester wins, a tie goes to the non-last owner
    always_comb begin
        any_req = m0_req | m1_req;
        winner  = (m0_req && m1_req) ? ~last_owner : m1_req;
        take    = (state == IDLE) && any_req;
    end

    // Next-state and memory strobe decode
    always_comb begin
        state_nxt = state;
        memwrite  = 1'b0;
        memread   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_req) state_nxt = ISSUE;
            end
            ISSUE: begin
                memwrite  = cmd_we;
                memread   = ~cmd_we;
                state_nxt = cmd_we ? IDLE : RDATA;
            end
            RDATA: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Command capture, grant/rvalid pulses, read return and grant counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= 1'b1;
            owner      <= 1'b0;
            cmd_we     <= 1'b0;
            memaddr    <= '0;
            writedata  <= '0;
            be         <= '0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            gcnt0      <= '0;
            gcnt1      <= '0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            if (take) begin
                last_owner <= winner;
                owner      <= winner;
                if (winner) begin
                    cmd_we    <= m1_we;
                    memaddr   <= m1_addr;
                    writedata <= m1_wdata;
                    be        <= m1_be;
                    m1_gnt    <= 1'b1;
                    gcnt1     <= gcnt1 + CNT_ONE;
                end else begin
                    cmd_we    <= m0_we;
                    memaddr   <= m0_addr;
                    writedata <= m0_wdata;
                    be        <= m0_be;
                    m0_gnt    <= 1'b1;
                    gcnt0     <= gcnt0 + CNT_ONE;
                end
            end
            if (state == RDATA) begin
                if (owner) begin
                    m1_rdata  <= readdata;
                    m1_rvalid <= 1'b1;
                end else begin
                    m0_rdata  <= readdata;
                    m0_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of each per-master grant counter.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports mN_req (N=0,1), input, 1 each: master N requests one transaction. m0 is the CPU; m1 is the DMA/peripheral master.
REQ-005 SHALL have ports mN_we, input, 1 each: 1 = write, 0 = read.
REQ-006 SHALL have ports mN_addr, input, 32 each: byte address.
REQ-007 SHALL have ports mN_wdata, input, 32 each: write data.
REQ-008 SHALL have ports mN_be, input, 4 each: byte enables.
REQ-009 SHALL have ports mN_gnt, output, 1 each: one-cycle pulse signalling that the command was accepted.
REQ-010 SHALL have ports mN_rvalid, output, 1 each: one-cycle pulse signalling that read data is valid.
REQ-011 SHALL have ports mN_rdata, output, 32 each: read return data.
REQ-012 SHALL have ports memaddr (output, 32), memwrite (output, 1), memread (output, 1), writedata (output, 32), be (output, 4): the shared data-memory command port.
REQ-013 SHALL have port readdata, input, 32: memory read data, valid one cycle after the memread cycle.
REQ-014 SHALL have ports busy (output, 1) and owner (output, 1): busy=1 whenever state is not IDLE; owner = index of the current or last granted master.
REQ-015 SHALL have ports gcnt0 and gcnt1, output, CNT_W each: grants issued per master.

Function
REQ-016 SHALL implement a state machine with states IDLE, ISSUE and RDATA.
REQ-017 SHALL sample mN_req only in IDLE; requests raised in ISSUE or RDATA wait until the next IDLE.
REQ-018 Arbitration SHALL be round-robin on a registered last-owner bit. With one requester, that requester wins. With both requesting, the master that is not the last owner wins.
REQ-019 IDLE with at least one request -> ISSUE. On that same edge the arbiter SHALL:
- register the winner's we, addr, wdata and be;
- set owner to the winner;
- set the winner's gnt for exactly one cycle;
- increment the winner's gcnt, wrapping modulo 2^CNT_W.
REQ-020 In ISSUE, memaddr, writedata and be SHALL come from the registered command. memwrite SHALL equal we and memread SHALL equal NOT we, for exactly that one cycle.
REQ-021 ISSUE -> IDLE for a write; ISSUE -> RDATA for a read.
REQ-022 In RDATA, readdata SHALL be captured into the owner's mN_rdata and that master's rvalid set for one cycle; next state IDLE.
REQ-023 Timing (request sampled at edge 0):
- gnt high in cycle 1;
- write occupies the memory in cycle 1 and the next arbitration is at edge 2;
- read rvalid is high in cycle 3 and the next arbitration is at edge 3.
REQ-024 Outside ISSUE, memwrite and memread SHALL be 0. memaddr, writedata and be SHALL hold their last values.
REQ-025 mN_rdata SHALL hold until that master's next read completes; the non-owner's rdata and rvalid SHALL be unaffected.
REQ-026 gnt and rvalid SHALL never be high for both masters in the same cycle.
REQ-027 gnt SHALL never be high for a master whose req was 0 at the arbitration edge.
REQ-028 A master holding req high after its gnt SHALL be treated as making a new request.

Reset
REQ-029 While reset is high, the following SHALL be held at their reset values:
- state = IDLE; last-owner = 1, so m0 wins the first tie;
- owner = 0; all gnt, rvalid, memwrite, memread and busy = 0;
- memaddr, writedata and be = 0; all rdata = 0; gcnt0 = gcnt1 = 0.
REQ-030 Reset asserted during ISSUE or RDATA SHALL abort the transaction; no rvalid SHALL be produced for the aborted read.
REQ-031 The first arbitration SHALL occur at the first rising edge after reset deasserts.

Verification
REQ-032 Single write: m0 writes 0xDEADBEEF to 0x40 with be=1111 -> m0_gnt in cycle 1; cycle 1 shows memwrite=1, memaddr=0x40, writedata=0xDEADBEEF; gcnt0=1.
REQ-033 Single read: m1 reads 0x80 and the memory returns 0x12345678 -> memread=1 in cycle 1, m1_rvalid=1 with m1_rdata=0x12345678 in cycle 3, m0_rvalid stays 0.
REQ-034 Contention: both masters request continuous writes after reset -> grants alternate m0, m1, m0, m1 on every other cycle; after 8 grants gcnt0=gcnt1=4.
REQ-035 Late request: m1 raises req during an m0 read's RDATA cycle -> m1 is not granted until the edge after RDATA, and m0_rvalid precedes m1_gnt by zero cycles of overlap.
REQ-036 Reset mid-read: reset asserted in the RDATA cycle -> all outputs return to 0 immediately, no rvalid is seen, and the next tie is won by m0.
REQ-037 Counter wrap: CNT_W=4 with 17 m0 grants -> gcnt0=1.
